// File: rtl/led_matrix_capture.sv
// led_matrix_capture
//   Receive side of a 4-column x 8-LED multiplexed scan. Registers and
//   polarity-normalises the column strobes and LED lines, then rebuilds the
//   four frame bytes. An LED is lit if it is seen lit on any accumulated cycle
//   of its column window, so PWM-dimmed LEDs are captured.
//
// Parameters
//   COL_ACTIVE_LOW : 1 -> lcol_in bit = 0 means the column is driven
//   LED_ACTIVE_LOW : 1 -> led_in bit = 0 means the LED is lit
//   SETTLE_CYCLES  : cycles a column must be solely active before sampling (1..255)
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   led_in[7:0]     : LED row lines, bit 0 = led1
//   lcol_in[3:0]    : column strobes, bit 0 = lcol1
//   leds1..leds4    : captured byte per column
//   frame_valid     : one-cycle pulse on a completed frame
//   frame_count     : completed frames, wraps 255 -> 0
//
// Optional build macro LEDCAP_ERRCHK_EN adds:
//   scan_err        : sticky, set on a multi-column window or a dropped frame
//   err_count[7:0]  : error events, saturating at 255
module led_matrix_capture #(
  parameter int unsigned COL_ACTIVE_LOW = 1,
  parameter int unsigned LED_ACTIVE_LOW = 1,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] led_in,
  input  logic [3:0] lcol_in,
  output logic [7:0] leds1,
  output logic [7:0] leds2,
  output logic [7:0] leds3,
  output logic [7:0] leds4,
  output logic       frame_valid,
  output logic [7:0] frame_count
`ifdef LEDCAP_ERRCHK_EN
  ,
  output logic       scan_err,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] SETTLE_N = SETTLE_CYCLES[7:0];

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

  state_t          state, state_n;
  logic [3:0]      col_s;
  logic [7:0]      led_s;
  logic [1:0]      cur, cur_n;
  logic [7:0]      cnt, cnt_n;
  logic [7:0]      acc, acc_n;
  logic [3:0]      seen, seen_n;
  logic [3:0][7:0] leds_q, leds_n;
  logic            fv_n;
  logic [7:0]      fc_n;
  logic            sole, multi;
  logic [1:0]      idx;
`ifdef LEDCAP_ERRCHK_EN
  logic            err_evt;
`endif

  // Exactly one column bit set -> sole column idx; two or more -> multi.
  always_comb begin
    sole  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    case (col_s)
      4'b0000: ;
      4'b0001: begin sole = 1'b1; idx = 2'd0; end
      4'b0010: begin sole = 1'b1; idx = 2'd1; end
      4'b0100: begin sole = 1'b1; idx = 2'd2; end
      4'b1000: begin sole = 1'b1; idx = 2'd3; end
      default: multi = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    acc_n   = acc;
    seen_n  = seen;
    leds_n  = leds_q;
    fv_n    = 1'b0;
    fc_n    = frame_count;
`ifdef LEDCAP_ERRCHK_EN
    err_evt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sole) begin
          state_n = SETTLE;
          cur_n   = idx;
          cnt_n   = 8'd1;
          acc_n   = '0;
        end
      end
      SETTLE: begin
        if (sole && idx == cur) begin
          // The cycle after SETTLE_N settled cycles is the first sampled one.
          if (cnt == SETTLE_N) begin
            state_n = ACCUM;
            acc_n   = led_s;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else if (multi) begin
          state_n = IDLE;
`ifdef LEDCAP_ERRCHK_EN
          err_evt = 1'b1;
`endif
        end else if (sole) begin
          cur_n = idx;
          cnt_n = 8'd1;
        end else begin
          state_n = IDLE;
        end
      end
      ACCUM: begin
        if (sole && idx == cur) begin
          acc_n = acc | led_s;
        end else if (multi) begin
          state_n = IDLE;
`ifdef LEDCAP_ERRCHK_EN
          err_evt = 1'b1;
`endif
        end else begin
          leds_n[cur] = acc;
          seen_n[cur] = 1'b1;
          if (cur == 2'd3) begin
            if (&seen[2:0]) begin
              fv_n = 1'b1;
              fc_n = frame_count + 8'd1;
            end else begin
`ifdef LEDCAP_ERRCHK_EN
              err_evt = 1'b1;
`endif
            end
            seen_n = '0;
          end
          // Release and the start of the next column happen in the same cycle.
          if (sole) begin
            state_n = SETTLE;
            cur_n   = idx;
            cnt_n   = 8'd1;
            acc_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_s       <= '0;
      led_s       <= '0;
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      acc         <= '0;
      seen        <= '0;
      leds_q      <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
    end else begin
      col_s       <= (COL_ACTIVE_LOW != 0) ? ~lcol_in : lcol_in;
      led_s       <= (LED_ACTIVE_LOW != 0) ? ~led_in : led_in;
      state       <= state_n;
      cur         <= cur_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      seen        <= seen_n;
      leds_q      <= leds_n;
      frame_valid <= fv_n;
      frame_count <= fc_n;
    end
  end

`ifdef LEDCAP_ERRCHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_err  <= 1'b0;
      err_count <= '0;
    end else if (err_evt) begin
      scan_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

  assign leds1 = leds_q[0];
  assign leds2 = leds_q[1];
  assign leds3 = leds_q[2];
  assign leds4 = leds_q[3];

endmodule

// File: tb/tb_led_matrix_capture.sv
module tb_led_matrix_capture;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led_in;
  logic [3:0] lcol_in;
  logic [7:0] leds1, leds2, leds3, leds4;
  logic       frame_valid;
  logic [7:0] frame_count;
`ifdef LEDCAP_ERRCHK_EN
  logic       scan_err;
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  led_matrix_capture #(
    .COL_ACTIVE_LOW(1),
    .LED_ACTIVE_LOW(1),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .led_in(led_in),
    .lcol_in(lcol_in),
    .leds1(leds1),
    .leds2(leds2),
    .leds3(leds3),
    .leds4(leds4),
    .frame_valid(frame_valid),
    .frame_count(frame_count)
`ifdef LEDCAP_ERRCHK_EN
    ,
    .scan_err(scan_err),
    .err_count(err_count)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses   = 0;

  // Reference model: tracks the current run of identical sole-column samples.
  int         m_run_col;
  int         m_run_len;
  logic [7:0] m_acc;
  bit         m_seen [4];
  logic [7:0] m_leds [4];
  logic [7:0] m_fc;
  bit         m_fv;
  logic [3:0] m_pcol;
  logic [7:0] m_pled;
  bit         m_err;
  int         m_errc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_err();
    m_err = 1'b1;
    if (m_errc < 255) m_errc++;
  endtask

  task automatic model_edge(input bit rst, input logic [3:0] lcol, input logic [7:0] led);
    logic [3:0] sc;
    logic [7:0] sl;
    int         sole;
    bit         multi;
    m_fv = 1'b0;
    if (rst) begin
      m_run_col = -1; m_run_len = 0; m_acc = '0;
      m_seen = '{default: 1'b0}; m_leds = '{default: 8'h00};
      m_fc = '0; m_pcol = '0; m_pled = '0; m_err = 1'b0; m_errc = 0;
      return;
    end
    sc = m_pcol;
    sl = m_pled;
    multi = ($countones(sc) > 1);
    sole = -1;
    if ($countones(sc) == 1)
      for (int i = 0; i < 4; i++) if (sc[i]) sole = i;
    if (m_run_col >= 0 && sole == m_run_col) begin
      m_run_len++;
      if (m_run_len > SETTLE) m_acc |= sl;
    end else begin
      if (m_run_col >= 0) begin
        if (multi) model_err();
        else if (m_run_len >= SETTLE + 1) begin
          m_leds[m_run_col] = m_acc;
          m_seen[m_run_col] = 1'b1;
          if (m_run_col == 3) begin
            if (m_seen[0] && m_seen[1] && m_seen[2]) begin
              m_fv = 1'b1;
              m_fc = m_fc + 8'd1;
            end else model_err();
            m_seen = '{default: 1'b0};
          end
        end
      end
      if (sole >= 0) begin
        m_run_col = sole; m_run_len = 1; m_acc = '0;
      end else m_run_col = -1;
    end
    m_pcol = ~lcol;
    m_pled = ~led;
  endtask

  task automatic tick(input bit rst, input logic [3:0] lcol, input logic [7:0] led);
    @(negedge clk);
    reset = rst; lcol_in = lcol; led_in = led;
    @(posedge clk);
    model_edge(rst, lcol, led);
    #1;
    if (frame_valid) pulses++;
    check("cycle", {23'd0, leds1, leds2, leds3, leds4, frame_valid, frame_count},
          {23'd0, m_leds[0], m_leds[1], m_leds[2], m_leds[3], m_fv, m_fc});
`ifdef LEDCAP_ERRCHK_EN
    check("cycle_err", {55'd0, scan_err, err_count}, {55'd0, m_err, m_errc[7:0]});
`endif
  endtask

  function automatic logic [3:0] cmask(input int c);
    logic [3:0] m;
    m = 4'hF;
    if (c >= 1 && c <= 4) m[c-1] = 1'b0;
    return m;
  endfunction

  task automatic scan(input int c, input logic [7:0] byte_v, input int n);
    repeat (n) tick(1'b0, cmask(c), ~byte_v);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] efc);
    check(name, {24'd0, leds1, leds2, leds3, leds4, frame_count}, {24'd0, e1, e2, e3, e4, efc});
  endtask

  typedef struct {
    logic [3:0]  lcol;
    logic [7:0]  led;
    int          len;
    logic [7:0]  e1, e2, e3, e4, efc;
    int unsigned epulse;
  } vec_t;

  vec_t vt [7];

  initial begin
    int unsigned p0;
    int          c, nextc, kind, len;
    logic [3:0]  m;

    vt[0] = '{4'b1110, ~8'hA5, 20, 8'hA5, 8'h00, 8'h00, 8'h00, 8'd0, 0};
    vt[1] = '{4'b1101, ~8'h3C, 20, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'd0, 0};
    vt[2] = '{4'b1011, ~8'h0F, 20, 8'hA5, 8'h3C, 8'h0F, 8'h00, 8'd0, 0};
    vt[3] = '{4'b0111, ~8'hFF, 20, 8'hA5, 8'h3C, 8'h0F, 8'hFF, 8'd1, 1};
    vt[4] = '{4'b1011, ~8'hFF, SETTLE, 8'hA5, 8'h3C, 8'h0F, 8'hFF, 8'd1, 0};
    vt[5] = '{4'b1011, ~8'h80, SETTLE + 1, 8'hA5, 8'h3C, 8'h80, 8'hFF, 8'd1, 0};
    vt[6] = '{4'b0111, ~8'h00, 20, 8'hA5, 8'h3C, 8'h80, 8'h00, 8'd1, 0};

    reset = 1'b1; lcol_in = 4'hF; led_in = 8'hFF;
    tick(1'b1, 4'hF, 8'hFF);
    tick(1'b1, 4'hF, 8'hFF);
    check_bytes("reset_state", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset_fv", {63'd0, frame_valid}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      p0 = pulses;
      repeat (vt[i].len) tick(1'b0, vt[i].lcol, vt[i].led);
      repeat (3) tick(1'b0, 4'hF, 8'hFF);
      check($sformatf("vec%0d_bytes", i), {24'd0, leds1, leds2, leds3, leds4, frame_count},
            {24'd0, vt[i].e1, vt[i].e2, vt[i].e3, vt[i].e4, vt[i].efc});
      check($sformatf("vec%0d_pulses", i), 64'(pulses - p0), 64'(vt[i].epulse));
    end

    // PWM: bit 0 lit only on cycles 10 and 11 of a 20-cycle col-2 window.
    for (int k = 1; k <= 20; k++) tick(1'b0, cmask(2), (k == 10 || k == 11) ? 8'hFE : 8'hFF);
    repeat (3) tick(1'b0, 4'hF, 8'hFF);
    check_bytes("pwm", 8'hA5, 8'h01, 8'h80, 8'h00, 8'd1);

    // Commit lands on the second edge after the release is presented.
    scan(1, 8'h5A, 10);
    tick(1'b0, 4'hF, 8'hFF);
    check("commit_edge1", {56'd0, leds1}, {56'd0, 8'hA5});
    tick(1'b0, 4'hF, 8'hFF);
    check("commit_edge2", {56'd0, leds1}, {56'd0, 8'h5A});

    // Direct switch; a minimum-length col-2 window proves settle starts on the switch.
    scan(1, 8'h11, 20);
    scan(2, 8'h22, SETTLE + 1);
    repeat (3) tick(1'b0, 4'hF, 8'hFF);
    check_bytes("direct_switch", 8'h11, 8'h22, 8'h80, 8'h00, 8'd1);

    // Frame 2 complete, then reset on the 10th cycle of the col-4 window of frame 3.
    for (int k = 1; k <= 4; k++) scan(k, 8'(1 << (k - 1)), 20);
    repeat (3) tick(1'b0, 4'hF, 8'hFF);
    check_bytes("frame2", 8'h01, 8'h02, 8'h04, 8'h08, 8'd2);
    for (int k = 1; k <= 3; k++) scan(k, 8'hC3, 20);
    scan(4, 8'hC3, 9);
    p0 = pulses;
    tick(1'b1, cmask(4), ~8'hC3);
    repeat (4) tick(1'b0, 4'hF, 8'hFF);
    check_bytes("mid_window_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("mid_window_reset_pulses", 64'(pulses - p0), 64'd0);

`ifdef LEDCAP_ERRCHK_EN
    scan(1, 8'h77, 3);
    repeat (8) tick(1'b0, 4'b1100, ~8'h77);
    repeat (3) tick(1'b0, 4'hF, 8'hFF);
    check("multi_col_err", {55'd0, scan_err, err_count}, {55'd0, 1'b1, 8'd1});
    check_bytes("multi_col_bytes", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    p0 = pulses;
    scan(1, 8'h01, 20); scan(3, 8'h03, 20); scan(4, 8'h04, 20);
    repeat (3) tick(1'b0, 4'hF, 8'hFF);
    check("drop_err", {55'd0, scan_err, err_count}, {55'd0, 1'b1, 8'd2});
    check("drop_pulses", 64'(pulses - p0), 64'd0);
`endif

    // Randomised scan segments checked every cycle against the model.
    nextc = 1;
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 19);
      len  = $urandom_range(1, 10);
      if (kind == 0) begin
        tick(1'b1, 4'hF, 8'hFF);
      end else begin
        if (kind <= 2) begin
          m = 4'hF;
          c = $urandom_range(0, 3);
          m[c] = 1'b0;
          m[(c + $urandom_range(1, 3)) % 4] = 1'b0;
        end else if (kind <= 4) begin
          m = 4'hF;
        end else if (kind <= 8) begin
          m = cmask($urandom_range(1, 4));
        end else begin
          m = cmask(nextc);
          nextc = nextc % 4 + 1;
        end
        repeat (len) tick(1'b0, m, 8'($urandom));
      end
    end
    repeat (3) tick(1'b0, 4'hF, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
